// File: rtl/tdm_pkg.sv
// Shared types and sizes for the 8:1 TDM link, used by both the receive
// deserialiser and the transmit-side scanner.
package tdm_pkg;

    localparam int SLOTS = 8;
    localparam int SEL_W = $clog2(SLOTS);

    typedef enum logic {
        HUNT    = 1'b0,
        COLLECT = 1'b1
    } tdm_state_t;

    typedef logic [SEL_W-1:0] slot_t;
    typedef logic [SLOTS-1:0] word_t;

    function automatic logic is_last_slot(slot_t slot);
        return slot == slot_t'(SLOTS - 1);
    endfunction

    function automatic word_t first_bit_word(logic d);
        return {{(SLOTS-1){1'b0}}, d};
    endfunction

endpackage

// File: rtl/tdm_demux18_if.sv
// Serial slot stream in, parallel word out with valid/ready and status pulses.
interface tdm_demux18_if;
    import tdm_pkg::*;

    logic  en;
    logic  sync;
    logic  d;
    slot_t s;
    word_t y;
    logic  y_valid;
    logic  y_ready;
    logic  frame_err;
    logic  overrun;

    modport master (
        output en, sync, d, y_ready,
        input  s, y, y_valid, frame_err, overrun
    );

    modport slave (
        input  en, sync, d, y_ready,
        output s, y, y_valid, frame_err, overrun
    );

endinterface

// File: rtl/tdm_slot_cnt.sv
// Slot index counter with clear, load-to-1 and wrapping increment.
module tdm_slot_cnt
    import tdm_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  inc,
    input  logic  load1,
    input  logic  clear,
    output slot_t cnt
);

    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (load1) begin
            cnt <= slot_t'(1);
        end else if (inc) begin
            cnt <= cnt + slot_t'(1);
        end
    end

endmodule

// File: rtl/tdm_demux18.sv
// TDM receive end: frame-aligns on sync, deserialises slot k into y[k] and
// presents each word on a valid/ready port with framing-error and overrun pulses.
module tdm_demux18
    import tdm_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    tdm_demux18_if.slave bus
);

    tdm_state_t state_q, state_d;
    slot_t      slot;
    word_t      shift_q;
    word_t      y_q;
    logic       y_valid_q;
    logic       frame_err_q;
    logic       overrun_q;

    logic       cnt_inc;
    logic       cnt_load1;
    logic       cnt_clear;
    logic       shift_write;
    logic       shift_restart;
    logic       shift_clear;
    logic       frame_err_d;
    logic       complete;
    logic       accept;
    word_t      word_new;

    tdm_slot_cnt u_slot_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (cnt_inc),
        .load1 (cnt_load1),
        .clear (cnt_clear),
        .cnt   (slot)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= HUNT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (bus.en) begin
            unique case (state_q)
                HUNT:    if (bus.sync) state_d = COLLECT;
                COLLECT: if (!bus.sync && slot == '0) state_d = HUNT;
                default: state_d = HUNT;
            endcase
        end
    end

    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        cnt_inc       = 1'b0;
        cnt_load1     = 1'b0;
        cnt_clear     = 1'b0;
        shift_write   = 1'b0;
        shift_restart = 1'b0;
        shift_clear   = 1'b0;
        frame_err_d   = 1'b0;
        complete      = 1'b0;
        if (bus.en) begin
            unique case (state_q)
                HUNT: begin
                    if (bus.sync) begin
                        shift_restart = 1'b1;
                        cnt_load1     = 1'b1;
                    end
                end
                COLLECT: begin
                    if (bus.sync) begin
                        // Sync at slot 0 is the expected realignment; anywhere else aborts the frame.
                        shift_restart = 1'b1;
                        cnt_load1     = 1'b1;
                        frame_err_d   = (slot != '0);
                    end else if (slot == '0) begin
                        shift_clear   = 1'b1;
                        cnt_clear     = 1'b1;
                        frame_err_d   = 1'b1;
                    end else begin
                        shift_write   = 1'b1;
                        cnt_inc       = 1'b1;
                        complete      = is_last_slot(slot);
                    end
                end
                default: begin
                    shift_clear = 1'b1;
                    cnt_clear   = 1'b1;
                end
            endcase
        end
    end

    // NOTE: the shift register is plain flops, so it takes the async reset like the rest of the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q <= '0;
        end else if (shift_clear) begin
            shift_q <= '0;
        end else if (shift_restart) begin
            shift_q <= first_bit_word(bus.d);
        end else if (shift_write) begin
            shift_q[slot] <= bus.d;
        end
    end

    // The last bit is taken straight from d so the word is ready on the completing edge.
    assign word_new = {bus.d, shift_q[SLOTS-2:0]};
    assign accept   = y_valid_q & bus.y_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q         <= '0;
            y_valid_q   <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            frame_err_q <= frame_err_d;
            overrun_q   <= 1'b0;
            if (complete) begin
                if (!y_valid_q || bus.y_ready) begin
                    y_q       <= word_new;
                    y_valid_q <= 1'b1;
                end else begin
                    overrun_q <= 1'b1;
                end
            end else if (accept) begin
                y_valid_q <= 1'b0;
            end
        end
    end

    assign bus.s         = slot;
    assign bus.y         = y_q;
    assign bus.y_valid   = y_valid_q;
    assign bus.frame_err = frame_err_q;
    assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_tdm_demux18.sv
// Directed and randomized stimulus for tdm_demux18, checked against a
// frame-level model built from bit queues.
module tb_tdm_demux18;
    import tdm_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    tdm_demux18_if bus ();

    tdm_demux18 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int    tests = 0;
    int    fails = 0;
    string step  = "init";

    // Reference model: collected bits of the current frame, delivered word, pulses.
    bit    m_locked;
    bit    m_bits[$];
    word_t m_y;
    bit    m_valid;
    bit    m_fe;
    bit    m_ov;
    bit    saw_fe;
    bit    saw_ov;

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s/%s: observed %0h expected %0h", step, tag, obs, exp);
        end
    endtask

    function automatic int m_slot();
        return m_locked ? m_bits.size() : 0;
    endfunction

    task automatic model_reset();
        m_locked = 1'b0;
        m_bits.delete();
        m_y     = '0;
        m_valid = 1'b0;
        m_fe    = 1'b0;
        m_ov    = 1'b0;
    endtask

    task automatic model_step(bit en, bit sync, bit d, bit rdy);
        word_t w        = '0;
        bit    complete = 1'b0;
        bit    accept   = m_valid && rdy;
        m_fe = 1'b0;
        m_ov = 1'b0;
        if (en) begin
            if (sync) begin
                if (m_locked && m_bits.size() != 0) m_fe = 1'b1;
                m_bits.delete();
                m_bits.push_back(d);
                m_locked = 1'b1;
            end else if (m_locked) begin
                if (m_bits.size() == 0) begin
                    m_fe     = 1'b1;
                    m_locked = 1'b0;
                end else begin
                    m_bits.push_back(d);
                    if (m_bits.size() == SLOTS) begin
                        for (int k = 0; k < SLOTS; k++) w[k] = m_bits[k];
                        complete = 1'b1;
                        m_bits.delete();
                    end
                end
            end
        end
        if (complete) begin
            if (!m_valid || rdy) begin
                m_y     = w;
                m_valid = 1'b1;
            end else begin
                m_ov = 1'b1;
            end
        end else if (accept) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic check_outputs();
        check("y",         bus.y,         m_y);
        check("y_valid",   bus.y_valid,   m_valid);
        check("s",         bus.s,         m_slot());
        check("frame_err", bus.frame_err, m_fe);
        check("overrun",   bus.overrun,   m_ov);
    endtask

    task automatic cycle(bit en, bit sync, bit d, bit rdy);
        bus.en      = en;
        bus.sync    = sync;
        bus.d       = d;
        bus.y_ready = rdy;
        @(posedge clk);
        #1;
        if (rst_n) model_step(en, sync, d, rdy);
        else       model_reset();
        saw_fe |= bus.frame_err;
        saw_ov |= bus.overrun;
        check_outputs();
    endtask

    task automatic send_frame(word_t w, int gap, bit rdy);
        for (int k = 0; k < SLOTS; k++) begin
            cycle(1'b1, k == 0, w[k], rdy);
            if (k < SLOTS - 1) begin
                for (int g = 0; g < gap; g++) begin
                    cycle(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rdy);
                    check("gap_s", bus.s, k + 1);
                end
            end
        end
    endtask

    initial begin
        bus.en      = 1'b0;
        bus.sync    = 1'b0;
        bus.d       = 1'b0;
        bus.y_ready = 1'b0;
        model_reset();

        step = "reset";
        repeat (3) @(posedge clk);
        #1;
        check_outputs();
        rst_n = 1'b1;

        step = "t1_a5";
        saw_fe = 1'b0;
        send_frame(8'hA5, 0, 1'b1);
        check("word",    bus.y,       8'hA5);
        check("valid",   bus.y_valid, 1'b1);
        check("no_ferr", saw_fe,      1'b0);

        step = "t2_b2b";
        send_frame(8'h01, 0, 1'b1);
        check("word0", bus.y, 8'h01);
        check("wrap",  bus.s, 0);
        send_frame(8'h80, 0, 1'b1);
        check("word1", bus.y,       8'h80);
        check("valid", bus.y_valid, 1'b1);

        step = "t3_gaps";
        send_frame(8'h3C, 2, 1'b1);
        check("word", bus.y, 8'h3C);

        step = "t4_early";
        saw_fe = 1'b0;
        cycle(1'b1, 1'b1, 1'b0, 1'b1);
        repeat (3) cycle(1'b1, 1'b0, 1'b0, 1'b1);
        check("s4", bus.s, 4);
        send_frame(8'hFF, 0, 1'b1);
        check("ferr", saw_fe, 1'b1);
        check("word", bus.y,  8'hFF);

        step = "t5_overrun";
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        saw_ov = 1'b0;
        send_frame(8'h11, 0, 1'b0);
        check("word0", bus.y,       8'h11);
        check("valid", bus.y_valid, 1'b1);
        send_frame(8'h22, 0, 1'b0);
        check("held",  bus.y,  8'h11);
        check("ovr",   saw_ov, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        check("drain", bus.y_valid, 1'b0);
        check("keep",  bus.y,       8'h11);

        step = "t6_reset";
        send_frame(8'h6B, 0, 1'b1);
        cycle(1'b1, 1'b1, 1'b1, 1'b1);
        repeat (4) cycle(1'b1, 1'b0, 1'b1, 1'b1);
        check("s5", bus.s, 5);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_y",     bus.y,       8'h00);
        check("async_valid", bus.y_valid, 1'b0);
        check("async_s",     bus.s,       0);
        model_reset();
        repeat (2) cycle(1'b1, 1'b0, 1'b1, 1'b1);
        rst_n = 1'b1;
        repeat (5) cycle(1'b1, 1'b0, 1'($urandom_range(0, 1)), 1'b1);
        check("hunt_s", bus.s, 0);
        send_frame(8'h5A, 0, 1'b1);
        check("word", bus.y, 8'h5A);

        step = "random";
        for (int n = 0; n < 600; n++) begin
            bit en   = ($urandom_range(0, 3) != 0);
            bit sync = (m_slot() == 0) ? ($urandom_range(0, 15) != 0)
                                       : ($urandom_range(0, 19) == 0);
            cycle(en, sync, 1'($urandom_range(0, 1)), ($urandom_range(0, 2) != 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
